// File: rtl/binary16_pkg.sv
// Shared binary16 definitions for the iterative multiplier and divider.
// Format constants, FSM states, operand classes and the classifier.
package binary16_pkg;

  localparam int EXP_W   = 5;
  localparam int MANT_W  = 10;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] INF  = 16'h7C00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULTIPLYING,
    ST_NORMALIZING
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Subnormals land in CLS_ZERO because they are flushed.
  function automatic cls_e classify(input logic [14:0] x);
    cls_e c;
    c = CLS_NORMAL;
    if (x[14:10] == 5'd31) begin
      c = (x[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
    end else if (x[14:10] == 5'd0) begin
      c = CLS_ZERO;
    end
    return c;
  endfunction

endpackage

// File: rtl/binary16_round_pack.sv
// Normalise a 22-bit significand product, round to nearest even and
// pack into binary16 with overflow to infinity and flush of underflow.
module binary16_round_pack
  import binary16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [21:0]       prod,
  output logic [15:0]       res
);

  logic [9:0]        m;
  logic [9:0]        mr;
  logic              g;
  logic              s;
  logic              up;
  logic              cy;
  logic signed [7:0] e;

  // Pick the leading-one position, round, then range-check the exponent.
  always_comb begin
    m  = prod[19:10];
    g  = prod[9];
    s  = |prod[8:0];
    e  = 8'(exp_in);
    if (prod[21]) begin
      m = prod[20:11];
      g = prod[10];
      s = |prod[9:0];
      e = 8'(exp_in) + 8'sd1;
    end
    up       = g & (s | m[0]);
    {cy, mr} = {1'b0, m} + {10'd0, up};
    if (cy) begin
      e = e + 8'sd1;
    end
    if (e >= 8'sd31) begin
      res = {sign, INF[14:0]};
    end else if (e <= 8'sd0) begin
      res = {sign, 15'd0};
    end else begin
      res = {sign, e[4:0], mr};
    end
  end

endmodule

// File: rtl/binary16_mul_seq.sv
// Iterative binary16 multiplier: one multiplier bit per cycle shift-add,
// fixed 12-cycle latency for every operand class, valid-pulse handshake.
module binary16_mul_seq
  import binary16_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        data_valid_in,
  output logic [15:0] result,
  output logic        data_valid_out,
  output logic        busy
);

  state_e            state;
  state_e            state_next;
  logic              sign;
  logic [21:0]       mant_a;
  logic [10:0]       mant_b;
  logic signed [6:0] exp_sum;
  cls_e              cls_a;
  cls_e              cls_b;
  logic [21:0]       acc;
  logic [3:0]        count;
  logic [15:0]       packed_res;
  logic [15:0]       final_res;

  assign busy = (state != ST_IDLE);

  binary16_round_pack u_round_pack (
    .sign   (sign),
    .exp_in (exp_sum),
    .prod   (acc),
    .res    (packed_res)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in idle, 11 multiply steps, one pack step.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (data_valid_in) begin
          state_next = ST_MULTIPLYING;
        end
      end
      ST_MULTIPLYING: begin
        if (count == 4'd0) begin
          state_next = ST_NORMALIZING;
        end
      end
      ST_NORMALIZING: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Special operands override the arithmetic result, NaN first.
  always_comb begin
    final_res = packed_res;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      final_res = QNAN;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      final_res = QNAN;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      final_res = {sign, INF[14:0]};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      final_res = {sign, 15'd0};
    end
  end

  // Operand capture, shift-add accumulation and result register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sign           <= 1'b0;
      mant_a         <= 22'd0;
      mant_b         <= 11'd0;
      exp_sum        <= 7'sd0;
      cls_a          <= CLS_ZERO;
      cls_b          <= CLS_ZERO;
      acc            <= 22'd0;
      count          <= 4'd0;
      result         <= 16'h0000;
      data_valid_out <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (data_valid_in) begin
            sign    <= a[15] ^ b[15];
            mant_a  <= {11'd0, 1'b1, a[9:0]};
            mant_b  <= {1'b1, b[9:0]};
            exp_sum <= $signed({2'b00, a[14:10]})
                     + $signed({2'b00, b[14:10]})
                     - 7'sd15;
            cls_a   <= classify(a[14:0]);
            cls_b   <= classify(b[14:0]);
            acc     <= 22'd0;
            count   <= 4'd10;
          end
        end
        ST_MULTIPLYING: begin
          if (mant_b[0]) begin
            acc <= acc + mant_a;
          end
          mant_a <= mant_a << 1;
          mant_b <= mant_b >> 1;
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end
        end
        ST_NORMALIZING: begin
          result         <= final_res;
          data_valid_out <= 1'b1;
        end
        default: begin
          data_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary16_mul_seq.sv
// Self-checking bench for binary16_mul_seq: arithmetic reference model,
// per-cycle output compare, directed corner cases and random operands.
module tb_binary16_mul_seq;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        data_valid_in = 1'b0;
  logic [15:0] result;
  logic        data_valid_out;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  binary16_mul_seq dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .data_valid_in  (data_valid_in),
    .result         (result),
    .data_valid_out (data_valid_out),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact integer product of significands, rounded arithmetically.
  function automatic logic [15:0] ref_mul(input logic [15:0] x,
                                          input logic [15:0] y);
    int ex, ey, fx, fy, e, sh, half;
    longint prod, q, r;
    bit nx, ny, ix, iy, zx, zy;
    logic s;
    logic [15:0] o;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = int'(x[9:0]);
    fy = int'(y[9:0]);
    s  = x[15] ^ y[15];
    nx = (ex == 31) && (fx != 0);
    ny = (ey == 31) && (fy != 0);
    ix = (ex == 31) && (fx == 0);
    iy = (ey == 31) && (fy == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    if (nx || ny) return 16'h7E00;
    if ((ix && zy) || (zx && iy)) return 16'h7E00;
    if (ix || iy) return {s, 15'h7C00};
    if (zx || zy) return {s, 15'h0000};
    prod = longint'(1024 + fx) * longint'(1024 + fy);
    e    = ex + ey - 15;
    sh   = (prod >= 64'd2097152) ? 11 : 10;
    if (sh == 11) e++;
    q    = prod >> sh;
    r    = prod - (q << sh);
    half = 1 << (sh - 1);
    if (r > half || (r == half && q[0])) q++;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    o = {s, 5'(e), 10'(q)};
    return o;
  endfunction

  // Cycle model: 12 cycles busy after accept, then a one-cycle pulse.
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_result = 16'h0;
  logic [15:0] m_pend = 16'h0;

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("busy", {15'd0, busy}, {15'd0, m_cnt != 0});
      check("valid_pulse", {15'd0, data_valid_out}, {15'd0, m_valid});
      check("result_reg", result, m_result);
    end
    if (rst) begin
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_result = 16'h0;
    end else if (m_cnt == 0) begin
      m_valid = 1'b0;
      if (data_valid_in) begin
        m_cnt  = 12;
        m_pend = ref_mul(a, b);
      end
    end else begin
      m_cnt--;
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        m_valid  = 1'b1;
        m_result = m_pend;
      end
    end
  end

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] exp);
    int lat;
    @(posedge clk_in);
    #1;
    a = x;
    b = y;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    lat = 0;
    while (lat < 20 && !data_valid_out) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    check("latency", 16'(lat), 16'd12);
    check("op_result", result, exp);
  endtask

  function automatic logic [15:0] rand_op();
    int k;
    logic [4:0] e;
    k = int'($urandom_range(0, 9));
    e = 5'($urandom_range(1, 30));
    if (k == 0) e = 5'd0;
    if (k == 1) e = 5'd31;
    if (k >= 2 && k <= 5) e = 5'($urandom_range(8, 22));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  initial begin
    logic [15:0] x, y;
    check("model_1x1", ref_mul(16'h3C00, 16'h3C00), 16'h3C00);
    check("model_2xm3", ref_mul(16'h4000, 16'hC200), 16'hC600);
    check("model_tie", ref_mul(16'h3E00, 16'h3C01), 16'h3E02);
    check("model_ovf", ref_mul(16'h7BFF, 16'h4000), 16'h7C00);
    check("model_inf0", ref_mul(16'h7C00, 16'h0000), 16'h7E00);

    @(posedge clk_in);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    check("rst_result", result, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_valid", {15'd0, data_valid_out}, 16'd0);

    run_op(16'h3C00, 16'h3C00, 16'h3C00);
    run_op(16'h4000, 16'hC200, 16'hC600);
    run_op(16'h3E00, 16'h3C01, 16'h3E02);
    run_op(16'h3C01, 16'h3C01, 16'h3C02);
    run_op(16'h7BFF, 16'h4000, 16'h7C00);
    run_op(16'h0400, 16'h0400, 16'h0000);
    run_op(16'h7C00, 16'h0000, 16'h7E00);
    run_op(16'hFC00, 16'h4000, 16'hFC00);
    run_op(16'h7E01, 16'h3C00, 16'h7E00);
    run_op(16'h8000, 16'h4500, 16'h8000);

    // Valid held every cycle with changing operands.
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_in);
      #1;
      a = rand_op();
      b = rand_op();
      data_valid_in = 1'b1;
    end
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    repeat (14) @(posedge clk_in);

    // Reset in the middle of a multiply.
    @(posedge clk_in);
    #1;
    a = 16'h4200;
    b = 16'h4400;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_result", result, 16'h0000);
    check("abort_valid", {15'd0, data_valid_out}, 16'd0);
    run_op(16'h4200, 16'h4400, 16'h4A00);

    for (int i = 0; i < 250; i++) begin
      x = rand_op();
      y = rand_op();
      run_op(x, y, ref_mul(x, y));
    end

    repeat (3) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
